fetch_sequencer: RTL

- Sequences the program counter against a variable-latency instruction memory.
- Holds the architectural fetch PC and issues one fetch at a time over a req/ack handshake.
- Buffers the returned instruction for decode, with back-pressure from decode.
- Applies branch redirects (conditional, unconditional, BR-to-register targets computed upstream) and squashes any fetch that is in flight when a redirect arrives.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/full_adder.sv | 13 +
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   // Fetch sequencer states: idle after reset, request outstanding,
   // squashed request outstanding, instruction buffered for decode.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   // Every instruction occupies four bytes; PCs advance by this amount.
   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Holding register for the instruction handed to decode, with its PC and
// link value. load captures a new instruction, clear drops the valid flag
// while leaving the data fields untouched.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic [ADDR_W-1:0]  link_in,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  pc_plus_four
);

   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  link_q, link_d;

   // Next buffer contents: load wins over clear (the two are never
   // requested together by the sequencer).
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      link_d  = link_q;
      if (clear) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         instr_d = instr_in;
         pc_d    = pc_in;
         link_d  = link_in;
      end
   end

   // Buffer registers; reset leaves an empty buffer whose link reads as 4.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         link_q  <= ADDR_W'(INSTR_BYTES);
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         link_q  <= link_d;
      end
   end

   assign instr_valid  = valid_q;
   assign instr        = instr_q;
   assign instr_pc     = pc_q;
   assign pc_plus_four = link_q;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder; chained into ripple incrementers for PC arithmetic.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer for a variable-latency instruction memory.
// One request outstanding at a time; a redirect that lands while a request
// is in flight leaves the old address on the bus until the memory answers,
// then the answer is discarded and the redirect target is fetched.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               stall,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  pc_plus_four
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  redirect_tgt;
   logic [ADDR_W-1:0]  pc_inc;
   logic [ADDR_W-1:0]  carry;
   logic               buf_load;
   logic               buf_clear;

   // Branch targets are always word aligned; the low bits are dropped here.
   assign redirect_tgt = redirect_pc & ALIGN_MASK;

   // fetch_pc + 4 as a ripple chain; the top bit needs no carry out, so the
   // sum wraps silently at 2^ADDR_W.
   assign carry[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < ADDR_W - 1; gi++) begin : g_inc
         full_adder u_fa (
            .a    (fetch_pc_q[gi]),
            .b    (STEP[gi]),
            .cin  (carry[gi]),
            .sum  (pc_inc[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate
   assign pc_inc[ADDR_W-1] = fetch_pc_q[ADDR_W-1] ^ STEP[ADDR_W-1] ^ carry[ADDR_W-1];

   // Next-state, next-PC and buffer control for the fetch handshake.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = REQ;
            if (redirect) begin
               fetch_pc_d = redirect_tgt;
            end
         end
         REQ: begin
            if (imem_ack && !redirect) begin
               buf_load   = 1'b1;
               fetch_pc_d = pc_inc;
               state_d    = HOLD;
            end else if (redirect && !imem_ack) begin
               fetch_pc_d = redirect_tgt;
               state_d    = DRAIN;
            end else if (redirect && imem_ack) begin
               fetch_pc_d = redirect_tgt;
               state_d    = REQ;
            end
         end
         DRAIN: begin
            if (redirect) begin
               fetch_pc_d = redirect_tgt;
            end
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         HOLD: begin
            if (redirect) begin
               buf_clear  = 1'b1;
               fetch_pc_d = redirect_tgt;
               state_d    = REQ;
            end else if (!stall) begin
               buf_clear = 1'b1;
               state_d   = REQ;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // The bus address is frozen while a request waits for its ack and
   // otherwise follows the PC that the next request will use.
   always_comb begin
      addr_d = fetch_pc_d;
      if ((state_q == REQ || state_q == DRAIN) && !imem_ack) begin
         addr_d = addr_q;
      end
   end

   // Sequencer state, architectural fetch PC and bus address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
   assign imem_addr = addr_q;

   fetch_buffer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_fetch_buffer (
      .clk          (clk),
      .reset        (reset),
      .load         (buf_load),
      .clear        (buf_clear),
      .instr_in     (imem_rdata),
      .pc_in        (fetch_pc_q),
      .link_in      (pc_inc),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .pc_plus_four (pc_plus_four)
   );

endmodule
